// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and a saturating stall counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               squash held entries and drop the same-cycle input
//   in_valid/in_ready   upstream handshake; in_data/in_ctrl upstream payload
//   out_valid/out_ready downstream handshake; out_data/out_ctrl registered payload
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
//
// out_ctrl is zero whenever out_valid is low, so a bubble never carries
// live control bits into the next stage.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 112,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT             state;
    stateT             nextState;

    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [15:0]       stallCnt;

    logic              outValid;
    logic              inReady;
    logic              acc;
    logic              con;

    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;
    logic              clrMainCtrl;
    logic              clrSkidCtrl;

    assign outValid = (state != EMPTY);

    // With the skid buffer, readiness depends only on state (plus flush),
    // so no combinational path runs from out_ready to in_ready.
    always_comb begin
        inReady = 1'b0;
        if (SKID_EN != 0) begin
            inReady = (state != FULL) && !flush;
        end else begin
            inReady = (!outValid || out_ready) && !flush;
        end
    end

    assign acc = in_valid && inReady;
    assign con = outValid && out_ready;

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        clrMainCtrl  = 1'b0;
        clrSkidCtrl  = 1'b0;
        if (flush) begin
            nextState   = EMPTY;
            clrMainCtrl = 1'b1;
            clrSkidCtrl = 1'b1;
        end else if (SKID_EN != 0) begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        nextState  = BUSY;
                        loadMainIn = 1'b1;
                    end
                end
                BUSY: begin
                    unique case (1'b1)
                        acc && con: begin
                            loadMainIn = 1'b1;
                        end
                        acc && !con: begin
                            nextState = FULL;
                            loadSkid  = 1'b1;
                        end
                        !acc && con: begin
                            nextState   = EMPTY;
                            clrMainCtrl = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    // The skid entry is always younger, so it only moves
                    // into main once the main entry has been consumed.
                    if (con) begin
                        nextState    = BUSY;
                        loadMainSkid = 1'b1;
                        clrSkidCtrl  = 1'b1;
                    end
                end
                default: begin
                    nextState = EMPTY;
                end
            endcase
        end else begin
            if (acc) begin
                nextState  = BUSY;
                loadMainIn = 1'b1;
            end else if (con) begin
                nextState   = EMPTY;
                clrMainCtrl = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainData <= '0;
            mainCtrl <= '0;
        end else if (loadMainIn) begin
            mainData <= in_data;
            mainCtrl <= in_ctrl;
        end else if (loadMainSkid) begin
            mainData <= skidData;
            mainCtrl <= skidCtrl;
        end else if (clrMainCtrl) begin
            mainCtrl <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidData <= '0;
            skidCtrl <= '0;
        end else if (loadSkid) begin
            skidData <= in_data;
            skidCtrl <= in_ctrl;
        end else if (clrSkidCtrl) begin
            skidCtrl <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (outValid && !out_ready && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid;
    assign out_data  = mainData;
    assign out_ctrl  = outValid ? mainCtrl : '0;
    assign stall_cnt = stallCnt;

endmodule
